rx: RTL and testbench

- UART receiver. Sits directly downstream of the transmit stage and consumes its serial line.
- Recovers frames of 1 start bit (0), WIDTH_DATA data bits sent MSB first, and NB_STOP stop bits (1). This is the same framing the transmit stage emits.
- Samples the line on ticks derived from an oversampling clock clk_rx running at OVS × baud.
- Presents each received word in a one-entry holding register with full, framing-error and overrun flags for the host logic.

---
 rtl/rx.sv | 165 ++++++++++++++++
 tb/tb_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx.sv
// UART receiver: 1 start, WIDTH_DATA data bits MSB first, NB_STOP stop bits.
// Ports: i_clk/i_rst, clk_rx (OVS x baud), i_rx line, i_re pop -> o_data, o_full, o_ferr, o_ovr.
module rx #(
  parameter int WIDTH_DATA = 8,
  parameter int NB_STOP    = 2,
  parameter int OVS        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  clk_rx,
  input  logic                  i_rx,
  input  logic                  i_re,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_full,
  output logic                  o_ferr,
  output logic                  o_ovr
);

  localparam int CW   = $clog2(OVS);
  localparam int BMAX = (WIDTH_DATA > NB_STOP) ? WIDTH_DATA : NB_STOP;
  localparam int BW   = $clog2(BMAX + 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic [WIDTH_DATA-1:0] sr, sr_n;
  logic                  bad, bad_n;
  logic                  load;

  logic rx_m, rx_s;
  logic ck_m, ck_s;
  logic tick;
  logic half, mid;

  // Edge flops reset high so releasing reset with clk_rx high
  // cannot fake a tick while rx_s still holds its reset value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      ck_m <= 1'b1;
      ck_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
      ck_m <= clk_rx;
      ck_s <= ck_m;
    end
  end

  assign tick = ck_m & ~ck_s;
  assign half = (cnt == CW'(OVS/2 - 1));
  assign mid  = (cnt == CW'(OVS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= WAIT_IDLE;
      cnt   <= '0;
      bcnt  <= '0;
      sr    <= '0;
      bad   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bcnt  <= bcnt_n;
      sr    <= sr_n;
      bad   <= bad_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bcnt_n  = bcnt;
    sr_n    = sr;
    bad_n   = bad;
    load    = 1'b0;
    if (tick) begin
      unique case (state)
        WAIT_IDLE: begin
          if (rx_s) state_n = IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            cnt_n   = '0;
            state_n = START;
          end
        end
        START: begin
          if (half) begin
            cnt_n   = '0;
            bcnt_n  = '0;
            bad_n   = 1'b0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        DATA: begin
          if (mid) begin
            cnt_n = '0;
            sr_n  = {sr[WIDTH_DATA-2:0], rx_s};
            if (bcnt == BW'(WIDTH_DATA - 1)) begin
              bcnt_n  = '0;
              state_n = STOP;
            end else begin
              bcnt_n = bcnt + BW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        STOP: begin
          if (mid) begin
            cnt_n = '0;
            bad_n = bad | ~rx_s;
            if (bcnt == BW'(NB_STOP - 1)) begin
              bcnt_n  = '0;
              load    = 1'b1;
              // A low last stop bit means break or a bad line:
              // insist on seeing it high before the next start.
              state_n = rx_s ? IDLE : WAIT_IDLE;
            end else begin
              bcnt_n = bcnt + BW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = WAIT_IDLE;
      endcase
    end
  end

  // A load in the same cycle as a read wins; the read took the old word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
      o_full <= 1'b0;
      o_ferr <= 1'b0;
      o_ovr  <= 1'b0;
    end else if (load) begin
      o_data <= sr;
      o_ferr <= bad | ~rx_s;
      o_full <= 1'b1;
      if (o_full && !i_re) begin
        o_ovr <= 1'b1;
      end else if (o_full && i_re) begin
        o_ovr <= 1'b0;
      end
    end else if (i_re && o_full) begin
      o_full <= 1'b0;
      o_ovr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: directed frames, scoreboard of expected loads.
// A monitor pops the queue on every load it observes at the outputs.
module tb_rx;

  localparam int WD  = 8;
  localparam int NS  = 2;
  localparam int OVS = 16;

  logic          i_clk  = 1'b0;
  logic          i_rst  = 1'b1;
  logic          clk_rx = 1'b0;
  logic          i_rx   = 1'b0;
  logic          i_re   = 1'b0;
  logic [WD-1:0] o_data;
  logic          o_full;
  logic          o_ferr;
  logic          o_ovr;

  rx #(
    .WIDTH_DATA(WD),
    .NB_STOP(NS),
    .OVS(OVS)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .clk_rx(clk_rx),
    .i_rx(i_rx),
    .i_re(i_re),
    .o_data(o_data),
    .o_full(o_full),
    .o_ferr(o_ferr),
    .o_ovr(o_ovr)
  );

  always #5 i_clk = ~i_clk;
  always #20 clk_rx = ~clk_rx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WD-1:0] d;
    logic          ferr;
    logic          ovr;
  } exp_t;

  exp_t q[$];

  logic [WD-1:0] data_q = '0;
  logic          full_q = 1'b0;
  logic          ovr_q  = 1'b0;

  always @(negedge i_clk) begin
    exp_t e;
    if (o_full && (!full_q || o_data != data_q || (o_ovr && !ovr_q))) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load: got data=%h ferr=%b ovr=%b, required no load",
                 o_data, o_ferr, o_ovr);
      end else begin
        e = q.pop_front();
        if (o_data !== e.d || o_ferr !== e.ferr || o_ovr !== e.ovr) begin
          errors++;
          $display("FAIL load: got data=%h ferr=%b ovr=%b, required data=%h ferr=%b ovr=%b",
                   o_data, o_ferr, o_ovr, e.d, e.ferr, e.ovr);
        end
      end
    end
    data_q = o_data;
    full_q = o_full;
    ovr_q  = o_ovr;
  end

  task automatic expect_ld(input logic [WD-1:0] d, input logic f, input logic o);
    exp_t e;
    e.d    = d;
    e.ferr = f;
    e.ovr  = o;
    q.push_back(e);
  endtask

  task automatic bit_out(input logic b, input int n);
    i_rx = b;
    repeat (n) @(posedge clk_rx);
  endtask

  // Start edge at E0; the last stop sample is taken on the tick of
  // clk_rx edge OVS*(WD+NS)+OVS/2+1, and the load lands on that tick.
  task automatic send(input logic [WD-1:0] d, input logic [NS-1:0] stops,
                      input bit re_at_load);
    bit_out(1'b0, OVS);
    for (int i = WD - 1; i >= 0; i--) bit_out(d[i], OVS);
    for (int i = 0; i < NS; i++) begin
      if (i == NS - 1 && re_at_load) begin
        i_rx = stops[i];
        repeat (OVS/2 + 1) @(posedge clk_rx);
        @(posedge i_clk);
        @(negedge i_clk);
        i_re = 1'b1;
        @(negedge i_clk);
        i_re = 1'b0;
        repeat (OVS/2 - 1) @(posedge clk_rx);
      end else begin
        bit_out(stops[i], OVS);
      end
    end
  endtask

  task automatic wait_full(input string name);
    int n;
    n = 0;
    while (!o_full && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_full) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: o_full=%b after %0d cycles, required 1", name, o_full, n);
    end
  endtask

  task automatic read(input string name);
    wait_full(name);
    @(negedge i_clk);
    i_re = 1'b1;
    @(negedge i_clk);
    i_re = 1'b0;
    checks++;
    if (o_full !== 1'b0 || o_ovr !== 1'b0) begin
      errors++;
      $display("FAIL %s: got full=%b ovr=%b, required full=0 ovr=0", name, o_full, o_ovr);
    end
  endtask

  task automatic chk(input string name, input logic [WD+2:0] got, input logic [WD+2:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got {data,full,ferr,ovr}=%h, required %h", name, got, req);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1;
    i_rx  = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset", {o_data, o_full, o_ferr, o_ovr}, '0);
    i_rst = 1'b0;

    // Line low out of reset, then high, then a good frame
    @(posedge clk_rx);
    bit_out(1'b0, 40 * OVS);
    bit_out(1'b1, 2 * OVS);
    expect_ld(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 2'b11, 1'b0);
    read("rd_a5");

    // Back-to-back frames with reads after each load
    bit_out(1'b1, OVS);
    expect_ld(8'h3C, 1'b0, 1'b0);
    expect_ld(8'hC3, 1'b0, 1'b0);
    fork
      begin
        send(8'h3C, 2'b11, 1'b0);
        send(8'hC3, 2'b11, 1'b0);
      end
      begin
        read("rd_3c");
        read("rd_c3");
      end
    join

    // Second stop bit low, line held low, then a good frame
    bit_out(1'b1, OVS);
    expect_ld(8'h5A, 1'b1, 1'b0);
    send(8'h5A, 2'b01, 1'b0);
    bit_out(1'b0, 3 * OVS);
    read("rd_5a");
    bit_out(1'b1, 2 * OVS);
    expect_ld(8'h01, 1'b0, 1'b0);
    send(8'h01, 2'b11, 1'b0);
    read("rd_01");

    // Overrun, then read clears it
    bit_out(1'b1, OVS);
    expect_ld(8'h11, 1'b0, 1'b0);
    expect_ld(8'h22, 1'b0, 1'b1);
    send(8'h11, 2'b11, 1'b0);
    send(8'h22, 2'b11, 1'b0);
    read("rd_ovr");

    // Read in the exact load cycle: no overrun
    bit_out(1'b1, OVS);
    expect_ld(8'h11, 1'b0, 1'b0);
    expect_ld(8'h22, 1'b0, 1'b0);
    send(8'h11, 2'b11, 1'b0);
    send(8'h22, 2'b11, 1'b1);
    @(negedge i_clk);
    chk("simul_load", {o_data, o_full, o_ferr, o_ovr}, {8'h22, 3'b100});

    // Short low glitch on an idle line
    bit_out(1'b1, OVS);
    bit_out(1'b0, OVS / 4);
    bit_out(1'b1, 4 * OVS);
    @(negedge i_clk);
    chk("glitch", {o_data, o_full, o_ferr, o_ovr}, {8'h22, 3'b100});

    // Reset in the middle of a 0xFF frame
    @(posedge clk_rx);
    bit_out(1'b0, OVS);
    bit_out(1'b1, 3 * OVS);
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("mid_reset", {o_data, o_full, o_ferr, o_ovr}, '0);
    i_rx = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge clk_rx);
    bit_out(1'b0, 2 * OVS);
    bit_out(1'b1, OVS);
    expect_ld(8'h96, 1'b0, 1'b0);
    send(8'h96, 2'b11, 1'b0);
    read("rd_96");

    repeat (4) @(negedge i_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d loads outstanding, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
